stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Sequencer for stack operations: PUSH, POP, CALL and RET.
- Drives the 4-entry, 8-bit register file through its ports: asynchronous read ports A and B, and a single synchronous write port with enable.
- R3 is the stack pointer (SP). The register file resets R3 to 255.
- Drives a single-port data memory with 1-cycle synchronous read. Sits between the decode stage and the register file / data memory. Decode stalls while `busy` is high.

Parameters:
- DATA_W, 8: data, SP and address width.
- REG_AW, 2: register index width.
- SP_IDX, 3: register index holding SP.

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-low reset.
- start  in  1: operation request, sampled only in IDLE.
- op  in  2: 0=PUSH, 1=POP, 2=CALL, 3=RET.
- src_reg  in  REG_AW: register pushed by PUSH.
- dst_reg  in  REG_AW: register loaded by POP.
- pc_ret  in  DATA_W: return address pushed by CALL.
- pc_target  in  DATA_W: jump target for CALL.
- rf_ra  out  REG_AW: register-file read address A, always SP_IDX.
- rf_rb  out  REG_AW: register-file read address B, equals src_reg.
- rf_ra_data  in  DATA_W: register-file read data A (SP value).
- rf_rb_data  in  DATA_W: register-file read data B.
- rf_we  out  1: register-file write enable.
- rf_rd  out  REG_AW: register-file write index.
- rf_wdata  out  DATA_W: register-file write data.
- mem_addr  out  DATA_W: data memory address.
- mem_wdata  out  DATA_W: data memory write data.
- mem_we  out  1: data memory write strobe.
- mem_re  out  1: data memory read strobe.
- mem_rdata  in  DATA_W: data memory read data, valid the cycle after mem_re.
- busy  out  1: high whenever state != IDLE.
- done  out  1: one-cycle completion pulse.
- pc_out  out  DATA_W: new PC value.
- pc_load  out  1: one-cycle PC load strobe.
- stk_wrap  out  1: SP wrapped; valid together with done.

Behaviour:
- States: IDLE, PUSH_MEM, PUSH_SP, POP_SP, POP_WB, DONE. Encoding is 3 bits.
- Accept (IDLE, start=1):
  - Latch sp_q=rf_ra_data, op_q, dst_q=dst_reg and tgt_q=pc_target.
  - Latch data_q: rf_rb_data for PUSH, pc_ret for CALL.
  - PUSH/CALL go to PUSH_MEM. POP/RET go to POP_SP.
- start in any other state is ignored. No queuing.
- PUSH_MEM: mem_we=1, mem_addr=sp_q, mem_wdata=data_q. Next state PUSH_SP.
- PUSH_SP: rf_we=1, rf_rd=SP_IDX, rf_wdata=sp_q-1 (mod 256). stk_wrap_q=(sp_q==0). Next state DONE.
- POP_SP:
  - rf_we=1, rf_rd=SP_IDX, rf_wdata=sp_q+1 (mod 256).
  - mem_re=1, mem_addr=sp_q+1. stk_wrap_q=(sp_q==255).
  - Next state POP_WB.
- POP_WB:
  - POP: rf_we=1, rf_rd=dst_q, rf_wdata=mem_rdata.
  - RET: rf_we=0; latch data_q=mem_rdata.
  - Next state DONE.
- DONE:
  - done=1, stk_wrap=stk_wrap_q.
  - CALL: pc_load=1, pc_out=tgt_q. RET: pc_load=1, pc_out=data_q.
  - Next state IDLE.
- Latency: accept at edge T0; done is high during cycle T3 for every op. Back-to-back throughput is one op per 4 cycles. A new start can be accepted in the cycle after DONE.
- POP with dst_reg=SP_IDX: the POP_WB write overrides the POP_SP write, so SP ends equal to the popped value.
- PUSH with src_reg=SP_IDX pushes the pre-decrement SP.
- SP arithmetic is modular 8-bit. Wrap is flagged via stk_wrap, never blocked.
- Strobes rf_we, mem_we, mem_re, done and pc_load are registered-state decodes, high only in their listed states and 0 otherwise. Address and data outputs are 0 when not in use.
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE. All outputs 0, except rf_ra=SP_IDX.
  - sp_q, data_q, tgt_q and stk_wrap_q are cleared.
  - No partial write completes after reset deasserts.

Decomposition:
- Shared package stack_pkg holds:
  - the op encodings (OP_PUSH, OP_POP, OP_CALL, OP_RET);
  - the state encodings;
  - SP_IDX and SP_RESET=255.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Reset, then PUSH with R1=0x5A and SP=255 -> T1: mem_we, addr 255, wdata 0x5A. T2: rf_we, rd 3, wdata 254. T3: done=1, stk_wrap=0.
- POP to R2 with SP=254 and M[255]=0x5A -> T1: rf_we rd 3 wdata 255, mem_re addr 255. T2: rf_we rd 2 wdata 0x5A. T3: done.
- CALL with pc_ret=0x11, pc_target=0x80, SP=255 -> M[255]=0x11, SP=254. In DONE: pc_load=1, pc_out=0x80. Then RET -> SP=255; in DONE: pc_load=1, pc_out=0x11, and rf_we stays 0 in POP_WB.
- Wrap: PUSH at SP=0 -> SP written 255 and stk_wrap=1 with done. POP at SP=255 -> mem addr 0, SP written 0, stk_wrap=1.
- start held high through a busy PUSH -> exactly one op per 4 cycles. start pulses during PUSH_MEM or PUSH_SP are ignored.
- rst low during PUSH_MEM -> busy, mem_we and rf_we go 0 immediately. After release, state is IDLE and no SP write occurs.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared encodings for the stack sequencer: opcodes, FSM states and SP constants.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPushMem = 3'd1,
    StPushSp  = 3'd2,
    StPopSp   = 3'd3,
    StPopWb   = 3'd4,
    StDone    = 3'd5
  } state_e;

  localparam int unsigned SP_IDX   = 3;
  localparam logic [7:0]  SP_RESET = 8'hFF;

endpackage

// File: rtl/stack_ctrl.sv
// Stack operation sequencer (PUSH/POP/CALL/RET) driving the register file and data memory.
// Every op takes four cycles from accept; strobes are pure decodes of the registered state.
module stack_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 2,
  parameter int unsigned SP_IDX = stack_pkg::SP_IDX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [REG_AW-1:0] src_reg,
  input  logic [REG_AW-1:0] dst_reg,
  input  logic [DATA_W-1:0] pc_ret,
  input  logic [DATA_W-1:0] pc_target,
  output logic [REG_AW-1:0] rf_ra,
  output logic [REG_AW-1:0] rf_rb,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] pc_out,
  output logic              pc_load,
  output logic              stk_wrap
);
  import stack_pkg::*;

  state_e            state_q, state_d;
  op_e               op_q;
  op_e               op_in;
  logic [REG_AW-1:0] dst_q;
  logic [DATA_W-1:0] sp_q, data_q, tgt_q;
  logic [DATA_W-1:0] sp_inc, sp_dec;
  logic              stk_wrap_q;
  logic              accept;

  assign op_in  = op_e'(op);
  assign sp_inc = sp_q + DATA_W'(1);
  assign sp_dec = sp_q - DATA_W'(1);
  assign accept = (state_q == StIdle) && start;

  always_comb begin
    state_d   = state_q;
    rf_ra     = REG_AW'(SP_IDX);
    rf_rb     = rst ? src_reg : '0;
    rf_we     = 1'b0;
    rf_rd     = '0;
    rf_wdata  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    busy      = (state_q != StIdle);
    done      = 1'b0;
    pc_out    = '0;
    pc_load   = 1'b0;
    stk_wrap  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = ((op_in == OP_PUSH) || (op_in == OP_CALL)) ? StPushMem : StPopSp;
        end
      end
      StPushMem: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = data_q;
        state_d   = StPushSp;
      end
      StPushSp: begin
        rf_we    = 1'b1;
        rf_rd    = REG_AW'(SP_IDX);
        rf_wdata = sp_dec;
        state_d  = StDone;
      end
      StPopSp: begin
        rf_we    = 1'b1;
        rf_rd    = REG_AW'(SP_IDX);
        rf_wdata = sp_inc;
        mem_re   = 1'b1;
        mem_addr = sp_inc;
        state_d  = StPopWb;
      end
      StPopWb: begin
        // RET keeps the popped word internally as the return PC.
        if (op_q == OP_POP) begin
          rf_we    = 1'b1;
          rf_rd    = dst_q;
          rf_wdata = mem_rdata;
        end
        state_d = StDone;
      end
      StDone: begin
        done     = 1'b1;
        stk_wrap = stk_wrap_q;
        if (op_q == OP_CALL) begin
          pc_load = 1'b1;
          pc_out  = tgt_q;
        end else if (op_q == OP_RET) begin
          pc_load = 1'b1;
          pc_out  = data_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= OP_PUSH;
      dst_q      <= '0;
      sp_q       <= '0;
      data_q     <= '0;
      tgt_q      <= '0;
      stk_wrap_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op_in;
        dst_q  <= dst_reg;
        sp_q   <= rf_ra_data;
        tgt_q  <= pc_target;
        data_q <= (op_in == OP_CALL) ? pc_ret : rf_rb_data;
      end
      if (state_q == StPushSp) stk_wrap_q <= (sp_q == '0);
      if (state_q == StPopSp)  stk_wrap_q <= (sp_q == '1);
      if ((state_q == StPopWb) && (op_q == OP_RET)) data_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural register file and data memory around it.
module tb_stack_ctrl;
  import stack_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [1:0] src_reg = 2'd0, dst_reg = 2'd0;
  logic [7:0] pc_ret = 8'd0, pc_target = 8'd0;
  logic [1:0] rf_ra, rf_rb, rf_rd;
  logic [7:0] rf_ra_data, rf_rb_data, rf_wdata;
  logic       rf_we, mem_we, mem_re, busy, done, pc_load, stk_wrap;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic [7:0] rf [4];
  logic [7:0] mem [256];
  logic [7:0] mem_q = 8'd0;
  logic       pre_rf = 1'b0, pre_mem = 1'b0;
  logic [7:0] pre_addr = 8'd0, pre_data = 8'd0;

  int n_cmp = 0;
  int n_err = 0;
  int n_done, n_we;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_reg   (src_reg),
    .dst_reg   (dst_reg),
    .pc_ret    (pc_ret),
    .pc_target (pc_target),
    .rf_ra     (rf_ra),
    .rf_rb     (rf_rb),
    .rf_ra_data(rf_ra_data),
    .rf_rb_data(rf_rb_data),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .pc_out    (pc_out),
    .pc_load   (pc_load),
    .stk_wrap  (stk_wrap)
  );

  // Environment: async-read register file, sync-write storage, 1-cycle memory read.
  always @(posedge clk) begin
    if (pre_rf) rf[pre_addr[1:0]] <= pre_data;
    else if (rf_we) rf[rf_rd] <= rf_wdata;
    if (pre_mem) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_q <= mem[mem_addr];
  end

  assign rf_ra_data = rf[rf_ra];
  assign rf_rb_data = rf[rf_rb];
  assign mem_rdata  = mem_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload_rf(input logic [1:0] idx, input logic [7:0] d);
    @(negedge clk);
    pre_rf = 1'b1; pre_addr = {6'd0, idx}; pre_data = d;
    @(negedge clk);
    pre_rf = 1'b0;
  endtask

  task automatic preload_mem(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_mem = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_mem = 1'b0;
  endtask

  // Returns at mid-cycle T1 (first cycle after the accepting edge).
  task automatic issue(input op_e o, input logic [1:0] s, input logic [1:0] d,
                       input logic [7:0] pr, input logic [7:0] pt);
    @(negedge clk);
    start = 1'b1; op = o; src_reg = s; dst_reg = d; pc_ret = pr; pc_target = pt;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rf_ra", rf_ra, 3);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_done", done, 0);
    chk("rst_pc_load", pc_load, 0);
    preload_rf(2'd3, SP_RESET);
    preload_rf(2'd1, 8'h5A);
    @(negedge clk);
    rst = 1'b1;

    // PUSH R1 at SP=255
    issue(OP_PUSH, 2'd1, 2'd0, 8'h00, 8'h00);
    chk("push_t1_mem_we", mem_we, 1);
    chk("push_t1_addr", mem_addr, 8'hFF);
    chk("push_t1_wdata", mem_wdata, 8'h5A);
    chk("push_t1_rf_we", rf_we, 0);
    chk("push_t1_busy", busy, 1);
    @(negedge clk);
    chk("push_t2_rf_we", rf_we, 1);
    chk("push_t2_rd", rf_rd, 3);
    chk("push_t2_wdata", rf_wdata, 8'hFE);
    chk("push_t2_mem_we", mem_we, 0);
    @(negedge clk);
    chk("push_t3_done", done, 1);
    chk("push_t3_wrap", stk_wrap, 0);
    chk("push_t3_pc_load", pc_load, 0);
    @(negedge clk);
    chk("push_idle_busy", busy, 0);
    chk("push_sp", rf[3], 8'hFE);

    // POP to R2 at SP=254
    issue(OP_POP, 2'd0, 2'd2, 8'h00, 8'h00);
    chk("pop_t1_rf_we", rf_we, 1);
    chk("pop_t1_rd", rf_rd, 3);
    chk("pop_t1_wdata", rf_wdata, 8'hFF);
    chk("pop_t1_mem_re", mem_re, 1);
    chk("pop_t1_addr", mem_addr, 8'hFF);
    @(negedge clk);
    chk("pop_t2_rf_we", rf_we, 1);
    chk("pop_t2_rd", rf_rd, 2);
    chk("pop_t2_wdata", rf_wdata, 8'h5A);
    @(negedge clk);
    chk("pop_t3_done", done, 1);
    chk("pop_t3_wrap", stk_wrap, 0);

    // CALL then RET
    issue(OP_CALL, 2'd0, 2'd0, 8'h11, 8'h80);
    chk("call_t1_addr", mem_addr, 8'hFF);
    chk("call_t1_wdata", mem_wdata, 8'h11);
    @(negedge clk);
    chk("call_t2_wdata", rf_wdata, 8'hFE);
    @(negedge clk);
    chk("call_t3_done", done, 1);
    chk("call_t3_pc_load", pc_load, 1);
    chk("call_t3_pc_out", pc_out, 8'h80);
    issue(OP_RET, 2'd0, 2'd0, 8'h00, 8'h00);
    chk("ret_t1_wdata", rf_wdata, 8'hFF);
    chk("ret_t1_addr", mem_addr, 8'hFF);
    @(negedge clk);
    chk("ret_t2_rf_we", rf_we, 0);
    @(negedge clk);
    chk("ret_t3_pc_load", pc_load, 1);
    chk("ret_t3_pc_out", pc_out, 8'h11);
    @(negedge clk);
    chk("ret_sp", rf[3], 8'hFF);
    chk("ret_pc_out_idle", pc_out, 0);

    // Wrap: PUSH at SP=0, then POP at SP=255
    preload_rf(2'd3, 8'h00);
    preload_rf(2'd0, 8'h77);
    issue(OP_PUSH, 2'd0, 2'd0, 8'h00, 8'h00);
    chk("wpush_t1_addr", mem_addr, 8'h00);
    @(negedge clk);
    chk("wpush_t2_wdata", rf_wdata, 8'hFF);
    @(negedge clk);
    chk("wpush_t3_done", done, 1);
    chk("wpush_t3_wrap", stk_wrap, 1);
    issue(OP_POP, 2'd0, 2'd1, 8'h00, 8'h00);
    chk("wpop_t1_addr", mem_addr, 8'h00);
    chk("wpop_t1_wdata", rf_wdata, 8'h00);
    @(negedge clk);
    chk("wpop_t2_wdata", rf_wdata, 8'h77);
    @(negedge clk);
    chk("wpop_t3_wrap", stk_wrap, 1);

    // start held high: one op per 4 cycles
    preload_rf(2'd3, 8'h40);
    @(negedge clk);
    start = 1'b1; op = OP_PUSH; src_reg = 2'd0;
    n_done = 0; n_we = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_done += int'(done);
      n_we   += int'(mem_we);
      if (i == 7) start = 1'b0;
    end
    chk("hold_done_cnt", n_done, 2);
    chk("hold_mem_we_cnt", n_we, 2);
    @(negedge clk);
    chk("hold_idle", busy, 0);
    chk("hold_sp", rf[3], 8'h3E);

    // start pulses inside a PUSH are ignored
    issue(OP_PUSH, 2'd0, 2'd0, 8'h00, 8'h00);
    start = 1'b1; op = OP_POP;
    @(negedge clk);
    chk("pulse_t2_wdata", rf_wdata, 8'h3D);
    start = 1'b0;
    @(negedge clk);
    chk("pulse_t3_done", done, 1);
    @(negedge clk);
    chk("pulse_idle", busy, 0);
    chk("pulse_sp", rf[3], 8'h3D);

    // Reset asserted mid-PUSH
    issue(OP_PUSH, 2'd0, 2'd0, 8'h00, 8'h00);
    chk("mid_t1_mem_we", mem_we, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_rf_we", rf_we, 0);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_done += int'(done);
    end
    chk("mid_after_done", n_done, 0);
    chk("mid_after_busy", busy, 0);
    chk("mid_after_sp", rf[3], 8'h3D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
